div_seq_ctrl: RTL and testbench

Sequential front/back-end for the 32-bit combinational array divider. Accepts operand requests over a valid/ready handshake and registers sign-magnitude operands into the divider inputs. After a fixed multicycle settle window, it captures the unsigned quotient and remainder, restores signs and presents the result over a second valid/ready handshake. It also handles divide-by-zero locally and never exposes the divider's unsettled outputs.

---
 rtl/div_seq_ctrl_if.sv | 29 ++
 rtl/div_seq_ctrl.sv | 107 ++++++++++
 tb/tb_div_seq_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/div_seq_ctrl_if.sv
// Request, result and divider-side signals of the sequential divider controller.
// The slave modport is the controller; master is the requester/consumer plus the array divider.
interface div_seq_ctrl_if;
   logic        in_valid;
   logic        in_ready;
   logic        in_signed;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic [31:0] div_a;
   logic [31:0] div_b;
   logic [31:0] div_q;
   logic [31:0] div_r;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_q;
   logic [31:0] out_r;
   logic        out_dbz;
   logic        busy;

   modport slave (
      input  in_valid, in_signed, in_a, in_b, div_q, div_r, out_ready,
      output in_ready, div_a, div_b, out_valid, out_q, out_r, out_dbz, busy
   );

   modport master (
      output in_valid, in_signed, in_a, in_b, div_q, div_r, out_ready,
      input  in_ready, div_a, div_b, out_valid, out_q, out_r, out_dbz, busy
   );
endinterface

// File: rtl/div_seq_ctrl.sv
// Sequencing front/back-end for a 32-bit combinational array divider: registers operand
// magnitudes, waits a fixed multicycle settle window, then restores signs on the result.
//
// state  | meaning
// IDLE   | waiting for a request, in_ready high
// SETTLE | divider inputs held, counting down the settle window
// DONE   | result presented, waiting for out_ready
module div_seq_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input logic           clk,
   input logic           rst_n,
   div_seq_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

   localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic        sign_a_q, sign_b_q;
   logic [31:0] div_a_q, div_b_q;
   logic [31:0] out_q_q, out_r_q;
   logic        out_valid_q, out_dbz_q;
   logic        in_ready_q, busy_q;

   logic        sign_a, sign_b;

   function automatic logic [31:0] neg32(input logic [31:0] v);
      return ~v + 32'd1;
   endfunction

   assign sign_a = bus.in_signed & bus.in_a[31];
   assign sign_b = bus.in_signed & bus.in_b[31];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         sign_a_q    <= 1'b0;
         sign_b_q    <= 1'b0;
         div_a_q     <= 32'd0;
         div_b_q     <= 32'd0;
         out_q_q     <= 32'd0;
         out_r_q     <= 32'd0;
         out_valid_q <= 1'b0;
         out_dbz_q   <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  sign_a_q   <= sign_a;
                  sign_b_q   <= sign_b;
                  div_a_q    <= sign_a ? neg32(bus.in_a) : bus.in_a;
                  div_b_q    <= sign_b ? neg32(bus.in_b) : bus.in_b;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  // Divide-by-zero never waits on the divider; result is known at accept.
                  if (bus.in_b == 32'd0) begin
                     out_q_q     <= 32'hFFFF_FFFF;
                     out_r_q     <= bus.in_a;
                     out_dbz_q   <= 1'b1;
                     out_valid_q <= 1'b1;
                     state_q     <= DONE;
                  end else begin
                     cnt_q   <= CNT_INIT;
                     state_q <= SETTLE;
                  end
               end
            end
            SETTLE: begin
               if (cnt_q == 4'd0) begin
                  out_q_q     <= (sign_a_q ^ sign_b_q) ? neg32(bus.div_q) : bus.div_q;
                  out_r_q     <= sign_a_q ? neg32(bus.div_r) : bus.div_r;
                  out_dbz_q   <= 1'b0;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.busy      = busy_q;
   assign bus.div_a     = div_a_q;
   assign bus.div_b     = div_b_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_q     = out_q_q;
   assign bus.out_r     = out_r_q;
   assign bus.out_dbz   = out_dbz_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl with a behavioural stand-in for the array divider.
module tb_div_seq_ctrl;
   localparam int SETTLE = 4;

   logic clk_sys = 1'b0;
   logic rst_n   = 1'b0;
   int   total   = 0;
   int   bad     = 0;

   div_seq_ctrl_if bus ();

   div_seq_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
      .clk   (clk_sys),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk_sys = ~clk_sys;

   // Unsigned array divider model
   assign bus.div_q = (bus.div_b == 32'd0) ? 32'hFFFF_FFFF : bus.div_a / bus.div_b;
   assign bus.div_r = (bus.div_b == 32'd0) ? bus.div_a : bus.div_a % bus.div_b;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   // Present a request and return once it is accepted (bounded).
   task automatic send(input logic sg, input logic [31:0] a, input logic [31:0] b,
                       input string tag);
      int n = 0;
      bus.in_valid  = 1'b1;
      bus.in_signed = sg;
      bus.in_a      = a;
      bus.in_b      = b;
      while (bus.in_ready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      chk({tag, ".acc_wait"}, 32'(n < 50), 32'd1);
      tick();
      bus.in_valid = 1'b0;
   endtask

   // Called #1 after the accept edge. exp_lat = further edges until out_valid shows.
   task automatic wait_result(input int exp_lat, input logic [31:0] eq, input logic [31:0] er,
                              input logic ed, input string tag);
      int lat = 0;
      while (bus.out_valid !== 1'b1 && lat < 50) begin
         tick();
         lat++;
      end
      chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, ".q"},   bus.out_q, eq);
      chk({tag, ".r"},   bus.out_r, er);
      chk({tag, ".dbz"}, 32'(bus.out_dbz), 32'(ed));
   endtask

   task automatic run(input logic sg, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] eda, input logic [31:0] edb,
                      input logic [31:0] eq, input logic [31:0] er, input logic ed,
                      input string tag);
      send(sg, a, b, tag);
      chk({tag, ".div_a"}, bus.div_a, eda);
      chk({tag, ".div_b"}, bus.div_b, edb);
      chk({tag, ".busy"},  32'(bus.busy), 32'd1);
      wait_result(ed ? 0 : SETTLE, eq, er, ed, tag);
      tick();
      chk({tag, ".vld_1cyc"}, 32'(bus.out_valid), 32'd0);
      chk({tag, ".rdy_back"}, 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_signed = 1'b0;
      bus.in_a      = 32'd0;
      bus.in_b      = 32'd0;
      bus.out_ready = 1'b1;
      #12;
      chk("rst.in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst.busy",     32'(bus.busy), 32'd0);
      chk("rst.valid",    32'(bus.out_valid), 32'd0);
      chk("rst.q",        bus.out_q, 32'd0);
      chk("rst.div_a",    bus.div_a, 32'd0);
      rst_n = 1'b1;
      tick();

      run(1'b0, 32'd100, 32'd7, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, "u100_7");
      run(1'b1, 32'hFFFF_FFF9, 32'd2, 32'd7, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, "s-7_2");
      run(1'b1, 32'd7, 32'hFFFF_FFFE, 32'd7, 32'd2, 32'hFFFF_FFFD, 32'd1, 1'b0, "s7_-2");
      run(1'b1, 32'h1234, 32'd0, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1, "s_dbz");
      run(1'b0, 32'h1234, 32'd0, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1, "u_dbz");
      run(1'b1, 32'hFFFF_FFF9, 32'd0, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, "s_dbz_neg");
      run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1,
          32'h8000_0000, 32'd0, 1'b0, "s_ovf");
      run(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF,
          32'd0, 32'h8000_0000, 1'b0, "u_ovf");

      // Backpressure with a competing request held on the input
      bus.out_ready = 1'b0;
      send(1'b0, 32'd100, 32'd7, "bp");
      wait_result(SETTLE, 32'd14, 32'd2, 1'b0, "bp");
      bus.in_valid = 1'b1;
      bus.in_a     = 32'd50;
      bus.in_b     = 32'd5;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp.valid", 32'(bus.out_valid), 32'd1);
         chk("bp.q",     bus.out_q, 32'd14);
         chk("bp.r",     bus.out_r, 32'd2);
         chk("bp.rdy",   32'(bus.in_ready), 32'd0);
         chk("bp.div_a", bus.div_a, 32'd100);
         chk("bp.div_b", bus.div_b, 32'd7);
      end
      bus.out_ready = 1'b1;
      tick();
      chk("bp.hs_valid", 32'(bus.out_valid), 32'd0);
      chk("bp.hs_rdy",   32'(bus.in_ready), 32'd1);
      chk("bp.hs_div_a", bus.div_a, 32'd100);
      chk("bp.hs_q",     bus.out_q, 32'd14);
      tick();
      bus.in_valid = 1'b0;
      chk("bp.new_div_a", bus.div_a, 32'd50);
      chk("bp.new_div_b", bus.div_b, 32'd5);
      wait_result(SETTLE, 32'd10, 32'd0, 1'b0, "bp_new");
      tick();

      // Reset in the middle of SETTLE
      send(1'b0, 32'd100, 32'd7, "rs");
      tick();
      rst_n = 1'b0;
      #1;
      chk("rs.valid", 32'(bus.out_valid), 32'd0);
      chk("rs.rdy",   32'(bus.in_ready), 32'd1);
      chk("rs.busy",  32'(bus.busy), 32'd0);
      chk("rs.q",     bus.out_q, 32'd0);
      chk("rs.r",     bus.out_r, 32'd0);
      chk("rs.dbz",   32'(bus.out_dbz), 32'd0);
      chk("rs.div_a", bus.div_a, 32'd0);
      chk("rs.div_b", bus.div_b, 32'd0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < SETTLE + 3; i++) begin
         tick();
         chk("rs.no_stale", 32'(bus.out_valid), 32'd0);
      end
      run(1'b0, 32'd1000, 32'd10, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, "u1000_10");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1);
   end
endmodule
